// File: rtl/or_det_pkg.sv
// Shared defaults and helpers for the OR-reduce detector and its channel filters.
package or_det_pkg;

    localparam int WIDTH_DEF  = 3;
    localparam int FILTER_DEF = 2;
    localparam int CNT_W_DEF  = 8;

    // Bits needed to hold values 0..v-1.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/or_chan_filter.sv
// One-channel glitch filter: filt only follows the raw input after it has
// disagreed with filt for FILTER consecutive cycles.
module or_chan_filter
    import or_det_pkg::*;
#(
    parameter int FILTER = FILTER_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic in_bit_i,
    output logic filt_o
);

    localparam int FC_W = clog2(FILTER + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER - 1);

    logic            filt_q, filt_d;
    logic [FC_W-1:0] fc_q, fc_d;

    always_comb begin
        filt_d = filt_q;
        fc_d   = fc_q;
        if (in_bit_i == filt_q) begin
            fc_d = '0;
        end else if (fc_q == FC_LAST) begin
            filt_d = in_bit_i;
            fc_d   = '0;
        end else begin
            fc_d = fc_q + FC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= 1'b0;
            fc_q   <= '0;
        end else begin
            filt_q <= filt_d;
            fc_q   <= fc_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/or_reduce_detector.sv
// Filtered, masked WIDTH-channel OR with edge detect, optional sticky output,
// source accumulation and a saturating rise-event counter.
module or_reduce_detector
    import or_det_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int FILTER = FILTER_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_bits,
    input  logic [WIDTH-1:0] mask,
    input  logic             sticky_en,
    input  logic             clear,
    output logic             gate_out,
    output logic             rise_pulse,
    output logic [WIDTH-1:0] src,
    output logic [CNT_W-1:0] event_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] act;
    logic             live, rise;

    logic             live_q;
    logic             gate_q, gate_d;
    logic             rise_q, rise_d;
    logic [WIDTH-1:0] src_q, src_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
        or_chan_filter #(.FILTER(FILTER)) u_filt (
            .clk      (clk),
            .rst      (rst),
            .in_bit_i (in_bits[gi]),
            .filt_o   (filt[gi])
        );
    end

    assign act  = filt & mask;
    assign live = |act;
    assign rise = live & ~live_q;

    // clear wins over every set/increment; live_q is deliberately left out so
    // a level held across clear does not look like a fresh rise afterwards.
    always_comb begin
        gate_d = sticky_en ? (gate_q | live) : live;
        rise_d = rise;
        src_d  = src_q | act;
        cnt_d  = (rise && cnt_q != CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;
        if (clear) begin
            gate_d = 1'b0;
            rise_d = 1'b0;
            src_d  = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q <= 1'b0;
            gate_q <= 1'b0;
            rise_q <= 1'b0;
            src_q  <= '0;
            cnt_q  <= '0;
        end else begin
            live_q <= live;
            gate_q <= gate_d;
            rise_q <= rise_d;
            src_q  <= src_d;
            cnt_q  <= cnt_d;
        end
    end

    assign gate_out    = gate_q;
    assign rise_pulse  = rise_q;
    assign src         = src_q;
    assign event_count = cnt_q;

endmodule

// File: tb/tb_or_reduce_detector.sv
// Directed bench for or_reduce_detector: a default instance plus a CNT_W=2
// instance on the same stimulus for the saturation case.
module tb_or_reduce_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] in_bits = '0;
    logic [2:0] mask = '0;
    logic       sticky_en = 1'b0;
    logic       clear = 1'b0;

    logic       gate_out, rise_pulse;
    logic [2:0] src;
    logic [7:0] event_count;

    logic       s_gate, s_rise;
    logic [2:0] s_src;
    logic [1:0] s_cnt;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    or_reduce_detector #(.WIDTH(3), .FILTER(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_bits(in_bits), .mask(mask),
        .sticky_en(sticky_en), .clear(clear),
        .gate_out(gate_out), .rise_pulse(rise_pulse), .src(src),
        .event_count(event_count)
    );

    or_reduce_detector #(.WIDTH(3), .FILTER(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_bits(in_bits), .mask(mask),
        .sticky_en(sticky_en), .clear(clear),
        .gate_out(s_gate), .rise_pulse(s_rise), .src(s_src),
        .event_count(s_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_all(input string tag, input logic g, input logic r,
                           input logic [2:0] s, input logic [7:0] c);
        chk({tag, ".gate"}, 32'(gate_out), 32'(g));
        chk({tag, ".rise"}, 32'(rise_pulse), 32'(r));
        chk({tag, ".src"},  32'(src), 32'(s));
        chk({tag, ".cnt"},  32'(event_count), 32'(c));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    initial begin
        // Reset asserted mid-cycle: outputs clear without waiting for an edge.
        tick(2);
        #3 rst = 1'b1;
        #1 chk_all("rst_imm", 1'b0, 1'b0, 3'b000, 8'd0);
        chk("rst_imm.sat", 32'(s_cnt), 32'd0);
        mask = 3'b111;
        tick(10);
        chk_all("rst_hold", 1'b0, 1'b0, 3'b000, 8'd0);
        rst = 1'b0;
        tick(2);
        chk_all("idle", 1'b0, 1'b0, 3'b000, 8'd0);

        // One-cycle glitch is rejected.
        in_bits = 3'b001;
        tick(1);
        in_bits = 3'b000;
        tick(4);
        chk_all("glitch", 1'b0, 1'b0, 3'b000, 8'd0);

        // Two-cycle level passes: filt at 2nd edge, outputs at 3rd.
        in_bits = 3'b001;
        tick(2);
        chk("lat.gate_early", 32'(gate_out), 32'd0);
        tick(1);
        chk_all("lat", 1'b1, 1'b1, 3'b001, 8'd1);
        tick(1);
        chk_all("lat.after", 1'b1, 1'b0, 3'b001, 8'd1);
        in_bits = 3'b000;
        tick(3);
        chk("fall.gate", 32'(gate_out), 32'd0);
        do_clear();
        chk_all("clr1", 1'b0, 1'b0, 3'b000, 8'd0);

        // Masked channel is ignored; simultaneous rises count once.
        mask = 3'b110;
        in_bits = 3'b001;
        tick(4);
        chk_all("masked", 1'b0, 1'b0, 3'b000, 8'd0);
        in_bits = 3'b110;
        tick(3);
        chk_all("simul", 1'b1, 1'b1, 3'b110, 8'd1);
        tick(2);
        chk_all("simul.hold", 1'b1, 1'b0, 3'b110, 8'd1);
        in_bits = 3'b000;
        tick(3);
        do_clear();
        chk_all("clr2", 1'b0, 1'b0, 3'b000, 8'd0);

        // Sticky holds gate_out after the channel drops.
        mask = 3'b111;
        sticky_en = 1'b1;
        in_bits = 3'b100;
        tick(4);
        in_bits = 3'b000;
        tick(4);
        chk_all("sticky", 1'b1, 1'b0, 3'b100, 8'd1);
        do_clear();
        chk_all("sticky.clr", 1'b0, 1'b0, 3'b000, 8'd0);
        tick(2);
        chk("sticky.clr_hold", 32'(gate_out), 32'd0);

        // Clear with the input held high: no new rise afterwards.
        in_bits = 3'b100;
        tick(3);
        chk_all("held", 1'b1, 1'b1, 3'b100, 8'd1);
        tick(1);
        do_clear();
        chk_all("held.clr", 1'b0, 1'b0, 3'b000, 8'd0);
        tick(1);
        chk_all("held.post", 1'b1, 1'b0, 3'b100, 8'd0);
        tick(3);
        chk_all("held.post2", 1'b1, 1'b0, 3'b100, 8'd0);

        // Dropping sticky_en lets gate_out follow live again.
        sticky_en = 1'b0;
        in_bits = 3'b000;
        tick(3);
        chk("unsticky.gate", 32'(gate_out), 32'd0);
        do_clear();

        // Saturation on the 2-bit counter instance.
        for (int k = 1; k <= 6; k++) begin
            in_bits = 3'b001;
            tick(3);
            chk($sformatf("sat%0d", k), 32'(s_cnt), 32'((k > 3) ? 3 : k));
            chk($sformatf("cnt%0d", k), 32'(event_count), 32'(k));
            in_bits = 3'b000;
            tick(3);
        end
        do_clear();
        chk("sat.clr", 32'(s_cnt), 32'd0);

        // Reset while a channel is part-way through its filter.
        in_bits = 3'b001;
        tick(1);
        #3 rst = 1'b1;
        #1 chk_all("midrst", 1'b0, 1'b0, 3'b000, 8'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(1);
        chk("midrst.e1", 32'(gate_out), 32'd0);
        tick(1);
        chk("midrst.e2", 32'(gate_out), 32'd0);
        tick(1);
        chk_all("midrst.e3", 1'b1, 1'b1, 3'b001, 8'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/or_reduce_detector.md
# or_reduce_detector

Parametrised, clocked successor to the three-input OR gate: a WIDTH-channel OR reduction with per-channel glitch filtering, a runtime channel mask, an optional sticky (latched) output and a saturating event counter. It is the front end for flag and status aggregation in the recognition datapath. Slow or noisy enable/valid flags enter here and leave as a single clean, countable "any asserted" indication. The latched source vector records which channels caused it.

## Interface
- WIDTH, 3: number of input channels (≥1).
- FILTER, 2: consecutive cycles a channel must disagree with its filtered value before the filtered value flips (≥1).
- CNT_W, 8: event counter width (≥1).

- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high; one clock, no other reset.
- in_bits  in  WIDTH  raw channel inputs, asynchronous to nothing (already in clk domain).
- mask  in  WIDTH  1 = channel participates in the OR; sampled every cycle.
- sticky_en  in  1  1 = gate_out holds once set until clear.
- clear  in  1  synchronous clear of sticky state, src and counter.
- gate_out  out  1  registered (sticky or live) masked OR.
- rise_pulse  out  1  one-cycle pulse on each 0→1 of the live OR.
- src  out  WIDTH  OR-accumulated filtered&mask channels since last clear.
- event_count  out  CNT_W  saturating count of rise_pulse events.

## Operation
- Per channel: filt[i] register and filter counter fc[i] (width clog2(FILTER+1)).
  - in_bits[i] == filt[i]: fc[i] ← 0.
  - else if fc[i] == FILTER-1: filt[i] ← in_bits[i], fc[i] ← 0.
  - else fc[i] ← fc[i]+1.
  - A pulse shorter than FILTER cycles never reaches filt.
- live = |(filt & mask), combinational; live_q registers live.
- rise = live & ~live_q.
- gate_out ← sticky_en ? (gate_out | live) : live.
  - Deasserting sticky_en makes gate_out follow live from the next edge.
- src ← src | (filt & mask).
- event_count ← event_count + 1 on rise, holding at 2^CNT_W−1 (no wrap).
- clear has priority over every set/increment in the same cycle.
  - gate_out ← 0, src ← 0, event_count ← 0, rise_pulse ← 0.
  - live_q still updates normally, so an input held high across clear produces no new rise.
- Filters, live_q and mask behaviour are unaffected by clear and sticky_en.
- Mask change alone can create or remove a rise; this counts as an event.

## Timing
- Reset values: filt=0, fc=0, live_q=0, gate_out=0, rise_pulse=0, src=0, event_count=0.
- Latency: in_bits change stable from edge k → filt flips at edge k+FILTER−1 → gate_out, rise_pulse, src, event_count update at edge k+FILTER.
  - FILTER=1: edge k updates filt, edge k+1 updates outputs.
- rise_pulse is registered: high exactly one cycle per 0→1 of live.
- Simultaneous rising channels in one cycle count as one event.
- A channel falling while another rises in the same cycle: live stays 1, no event.
- Async rst mid-filter discards partial counts. Outputs go to reset values immediately, not at the next edge.
- No handshake; all outputs valid every cycle after reset release.

## Structure
- Package or_det_pkg holds the default parameter constants and a clog2 helper function for fc width.
- One natural sub-module, or_chan_filter: one channel's filt/fc logic, instantiated WIDTH times via generate.
- Top level holds the reduction, edge detect, sticky/src logic and counter.

## Test plan
- Reset/default: WIDTH=3, FILTER=2, all inputs 0, assert rst mid-cycle → all outputs 0 immediately; hold 10 cycles, still 0.
- Glitch reject: in_bits=3'b001 for 1 cycle → gate_out stays 0, event_count=0. Hold 3'b001 for 2 cycles → gate_out=1 two edges after first sample, rise_pulse one cycle, event_count=1, src=3'b001.
- Mask and simultaneity: mask=3'b110, in_bits=3'b001 → no output. Then in_bits=3'b110 together → one event, src=3'b110.
- Sticky: sticky_en=1, pulse channel 2 for 4 cycles then drop → gate_out stays 1. clear → gate_out=0, src=0, count=0 next edge. clear with input held high → no new rise.
- Saturation: CNT_W=2, six filtered 0→1 toggles → event_count 1,2,3,3,3,3.
- Reset mid-operation: rst asserted while fc=1 on a rising channel → after release that channel needs a full FILTER cycles again before gate_out rises.
